// File: rtl/guess_entry_ctrl_if.sv
// Guess handshake and entry status between the entry controller and the checker.
// Pure wiring, no latency.
// guess_valid/guess_ack form the only flow control; status lines are plain strobes.
interface guess_entry_ctrl_if;
    logic [15:0] guess;
    logic        guess_valid;
    logic        guess_ack;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic        dup_err;
    logic [3:0]  tries;
    logic        locked;

    modport master (
        output guess, guess_valid, key_code, key_pulse, dup_err, tries, locked,
        input  guess_ack
    );

    modport slave (
        input  guess, guess_valid, key_code, key_pulse, dup_err, tries, locked,
        output guess_ack
    );
endinterface

// File: rtl/guess_entry_ctrl.sv
// Debounces the digit/backspace keypad and assembles a 4-distinct-digit guess.
// Latency: raw press to buffer update is 2 sync + DEBOUNCE_CYCLES cycles.
// Backpressure: guess is held until guess_ack; digits beyond the 4th are dropped.
module guess_entry_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         MAX_TRIES       = 10,
    parameter logic [3:0] EMPTY_NIBBLE    = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         key,
    input  logic               del,
    guess_entry_ctrl_if.master bus
);

    localparam int            CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    TRIES_MAX = 4'(MAX_TRIES);
    localparam logic [15:0]   EMPTY_BUF = {4{EMPTY_NIBBLE}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } db_state_t;

    logic [10:0]   sync1, sync2;
    db_state_t     state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [10:0]   vec_q, vec_nxt;
    logic          accept;
    logic          one_hot;

    logic [15:0] guess_q, guess_nxt;
    logic [2:0]  count_q, count_nxt;
    logic        valid_q;
    logic [3:0]  code_q, code_nxt;
    logic        pulse_q, pulse_nxt;
    logic        dup_q, dup_nxt;
    logic [3:0]  tries_q, tries_nxt;
    logic        locked_q, locked_nxt;

    logic [3:0]  digit;
    logic        in_buf;
    logic        ack_ok;
    logic [1:0]  slot;
    logic [3:0]  shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {del, key};
            sync2 <= sync1;
        end
    end

    assign one_hot = (sync2 != '0) && ((sync2 & (sync2 - 11'd1)) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            vec_q   <= vec_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        vec_nxt   = vec_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (one_hot) begin
                    state_nxt = ST_PRESS;
                    vec_nxt   = sync2;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS: begin
                if (sync2 != vec_q) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_HELD;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (sync2 == '0) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                // Any bounce during release restarts the quiet period.
                if (sync2 != '0) begin
                    cnt_nxt = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The latched vector is one-hot, so an OR-encoder is sufficient.
    assign digit = {vec_q[8] | vec_q[9],
                    vec_q[4] | vec_q[5] | vec_q[6] | vec_q[7],
                    vec_q[2] | vec_q[3] | vec_q[6] | vec_q[7],
                    vec_q[1] | vec_q[3] | vec_q[5] | vec_q[7] | vec_q[9]};

    assign in_buf = (guess_q[15:12] == digit) || (guess_q[11:8] == digit) ||
                    (guess_q[7:4]   == digit) || (guess_q[3:0]  == digit);

    assign ack_ok = bus.guess_ack && valid_q;
    assign slot   = vec_q[10] ? 2'(count_q - 3'd1) : count_q[1:0];
    assign shamt  = {slot, 2'b00};

    always_comb begin
        guess_nxt  = guess_q;
        count_nxt  = count_q;
        code_nxt   = code_q;
        pulse_nxt  = 1'b0;
        dup_nxt    = 1'b0;
        tries_nxt  = tries_q;
        locked_nxt = locked_q;
        if (ack_ok) begin
            guess_nxt = EMPTY_BUF;
            count_nxt = 3'd0;
            if (tries_q != TRIES_MAX) begin
                tries_nxt = tries_q + 4'd1;
            end
            locked_nxt = locked_q | (tries_nxt == TRIES_MAX);
        end else if (accept && !locked_q && !bus.guess_ack) begin
            if (vec_q[10]) begin
                if (count_q != 3'd0) begin
                    guess_nxt = (guess_q & ~(16'hF000 >> shamt)) |
                                ({EMPTY_NIBBLE, 12'h000} >> shamt);
                    count_nxt = count_q - 3'd1;
                end
            end else if (in_buf) begin
                dup_nxt   = 1'b1;
                pulse_nxt = 1'b1;
                code_nxt  = digit;
            end else if (count_q < 3'd4) begin
                guess_nxt = (guess_q & ~(16'hF000 >> shamt)) | ({digit, 12'h000} >> shamt);
                count_nxt = count_q + 3'd1;
                pulse_nxt = 1'b1;
                code_nxt  = digit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            guess_q  <= EMPTY_BUF;
            count_q  <= 3'd0;
            valid_q  <= 1'b0;
            code_q   <= 4'd0;
            pulse_q  <= 1'b0;
            dup_q    <= 1'b0;
            tries_q  <= 4'd0;
            locked_q <= 1'b0;
        end else begin
            guess_q  <= guess_nxt;
            count_q  <= count_nxt;
            valid_q  <= (count_nxt == 3'd4);
            code_q   <= code_nxt;
            pulse_q  <= pulse_nxt;
            dup_q    <= dup_nxt;
            tries_q  <= tries_nxt;
            locked_q <= locked_nxt;
        end
    end

    assign bus.guess       = guess_q;
    assign bus.guess_valid = valid_q;
    assign bus.key_code    = code_q;
    assign bus.key_pulse   = pulse_q;
    assign bus.dup_err     = dup_q;
    assign bus.tries       = tries_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl with a short debounce window.
module tb_guess_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key = '0;
    logic       del = 1'b0;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    int         pulse_total = 0;
    int         dup_total   = 0;
    int         last_pulse_cyc = 0;
    bit         valid_at_pulse = 1'b0;
    logic [3:0] codes[$];

    int pbase;
    int dbase;
    int start;

    guess_entry_ctrl_if bus ();

    guess_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .MAX_TRIES      (10),
        .EMPTY_NIBBLE   (4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .del(del),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.key_pulse === 1'b1) begin
            pulse_total++;
            codes.push_back(bus.key_code);
            last_pulse_cyc = cyc;
            valid_at_pulse = bus.guess_valid;
        end
        if (bus.dup_err === 1'b1) dup_total++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_vec(input logic [10:0] v, input int hold, input int rel);
        {del, key} = v;
        tick(hold);
        {del, key} = '0;
        tick(rel);
    endtask

    task automatic press_digit(input int d);
        press_vec(11'b1 << d, 10, 10);
    endtask

    task automatic press_del();
        press_vec(11'b100_0000_0000, 10, 10);
    endtask

    task automatic ack_pulse();
        bus.guess_ack = 1'b1;
        tick(1);
        bus.guess_ack = 1'b0;
    endtask

    task automatic do_reset();
        {del, key}    = '0;
        bus.guess_ack = 1'b0;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        bus.guess_ack = 1'b0;
        #2 rst = 1'b0;
        tick(3);
        checks++; if (bus.guess !== 16'hFFFF) begin failures++; $display("FAIL reset_guess: got %h expected %h", bus.guess, 16'hFFFF); end
        checks++; if (bus.guess_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.guess_valid); end
        checks++; if (bus.key_code !== 4'd0) begin failures++; $display("FAIL reset_key_code: got %h expected 0", bus.key_code); end
        checks++; if (bus.key_pulse !== 1'b0) begin failures++; $display("FAIL reset_key_pulse: got %b expected 0", bus.key_pulse); end
        checks++; if (bus.dup_err !== 1'b0) begin failures++; $display("FAIL reset_dup_err: got %b expected 0", bus.dup_err); end
        checks++; if (bus.tries !== 4'd0) begin failures++; $display("FAIL reset_tries: got %0d expected 0", bus.tries); end
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_entry();
        pbase = pulse_total;
        start = cyc;
        press_digit(1);
        checks++; if (last_pulse_cyc - start !== 7) begin failures++; $display("FAIL entry_latency: got %0d expected 7", last_pulse_cyc - start); end
        press_digit(2);
        press_digit(3);
        checks++; if (bus.guess !== 16'h123F || bus.guess_valid !== 1'b0) begin failures++; $display("FAIL entry_three: got %h/%b expected 123f/0", bus.guess, bus.guess_valid); end
        press_digit(4);
        checks++; if (pulse_total - pbase !== 4) begin failures++; $display("FAIL entry_pulses: got %0d expected 4", pulse_total - pbase); end
        checks++; if ({codes[codes.size()-4], codes[codes.size()-3], codes[codes.size()-2], codes[codes.size()-1]} !== 16'h1234) begin
            failures++; $display("FAIL entry_codes: got %h%h%h%h expected 1234", codes[codes.size()-4], codes[codes.size()-3], codes[codes.size()-2], codes[codes.size()-1]); end
        checks++; if (bus.guess !== 16'h1234 || bus.guess_valid !== 1'b1) begin failures++; $display("FAIL entry_full: got %h/%b expected 1234/1", bus.guess, bus.guess_valid); end
        checks++; if (valid_at_pulse !== 1'b1) begin failures++; $display("FAIL entry_valid_edge: got %b expected 1", valid_at_pulse); end
        press_digit(5);
        checks++; if (pulse_total - pbase !== 4 || bus.guess !== 16'h1234) begin failures++; $display("FAIL entry_fifth: got %0d/%h expected 4/1234", pulse_total - pbase, bus.guess); end
        press_del();
        checks++; if (bus.guess !== 16'h123F || bus.guess_valid !== 1'b0) begin failures++; $display("FAIL entry_del_full: got %h/%b expected 123f/0", bus.guess, bus.guess_valid); end
        ack_pulse();
        tick(1);
        checks++; if (bus.tries !== 4'd0 || bus.guess !== 16'h123F) begin failures++; $display("FAIL entry_stray_ack: got %0d/%h expected 0/123f", bus.tries, bus.guess); end
    endtask

    task automatic test_dup_del();
        do_reset();
        pbase = pulse_total;
        dbase = dup_total;
        press_digit(1);
        press_digit(2);
        press_digit(2);
        checks++; if (dup_total - dbase !== 1) begin failures++; $display("FAIL dup_count: got %0d expected 1", dup_total - dbase); end
        checks++; if (pulse_total - pbase !== 3 || codes[codes.size()-1] !== 4'd2) begin failures++; $display("FAIL dup_pulse: got %0d/%h expected 3/2", pulse_total - pbase, codes[codes.size()-1]); end
        checks++; if (bus.guess !== 16'h12FF) begin failures++; $display("FAIL dup_guess: got %h expected 12ff", bus.guess); end
        press_del();
        checks++; if (bus.guess !== 16'h1FFF) begin failures++; $display("FAIL del_guess: got %h expected 1fff", bus.guess); end
        press_digit(5);
        checks++; if (bus.guess !== 16'h15FF) begin failures++; $display("FAIL del_refill: got %h expected 15ff", bus.guess); end
        press_del();
        press_del();
        press_del();
        checks++; if (bus.guess !== 16'hFFFF || dup_total - dbase !== 1) begin failures++; $display("FAIL del_empty: got %h/%0d expected ffff/1", bus.guess, dup_total - dbase); end
    endtask

    task automatic test_bounce();
        do_reset();
        pbase = pulse_total;
        for (int i = 0; i < 5; i++) begin
            key[7] = 1'b1;
            tick(2);
            key[7] = 1'b0;
            tick(2);
        end
        press_vec(11'b000_1000_0000, 10, 10);
        checks++; if (pulse_total - pbase !== 1 || codes[codes.size()-1] !== 4'd7) begin failures++; $display("FAIL bounce_pulse: got %0d/%h expected 1/7", pulse_total - pbase, codes[codes.size()-1]); end
        checks++; if (bus.guess !== 16'h7FFF) begin failures++; $display("FAIL bounce_guess: got %h expected 7fff", bus.guess); end
        press_vec(11'b000_0010_1000, 10, 10);
        checks++; if (pulse_total - pbase !== 1 || bus.guess !== 16'h7FFF) begin failures++; $display("FAIL two_keys: got %0d/%h expected 1/7fff", pulse_total - pbase, bus.guess); end
    endtask

    task automatic test_ack();
        do_reset();
        press_digit(5);
        press_digit(6);
        press_digit(7);
        press_digit(8);
        tick(5);
        checks++; if (bus.guess !== 16'h5678 || bus.guess_valid !== 1'b1) begin failures++; $display("FAIL ack_pre: got %h/%b expected 5678/1", bus.guess, bus.guess_valid); end
        ack_pulse();
        checks++; if (bus.guess !== 16'hFFFF || bus.guess_valid !== 1'b0) begin failures++; $display("FAIL ack_clear: got %h/%b expected ffff/0", bus.guess, bus.guess_valid); end
        checks++; if (bus.tries !== 4'd1) begin failures++; $display("FAIL ack_tries: got %0d expected 1", bus.tries); end
        ack_pulse();
        tick(1);
        checks++; if (bus.tries !== 4'd1) begin failures++; $display("FAIL ack_ignored: got %0d expected 1", bus.tries); end
    endtask

    task automatic test_lockout();
        for (int r = 0; r < 9; r++) begin
            press_digit(1);
            press_digit(2);
            press_digit(3);
            press_digit(4);
            if (r == 8) begin
                checks++; if (bus.tries !== 4'd9 || bus.locked !== 1'b0) begin failures++; $display("FAIL lock_pre: got %0d/%b expected 9/0", bus.tries, bus.locked); end
            end
            ack_pulse();
        end
        checks++; if (bus.tries !== 4'd10 || bus.locked !== 1'b1) begin failures++; $display("FAIL lock_set: got %0d/%b expected 10/1", bus.tries, bus.locked); end
        pbase = pulse_total;
        press_digit(3);
        press_digit(6);
        checks++; if (pulse_total - pbase !== 0 || bus.guess !== 16'hFFFF) begin failures++; $display("FAIL lock_ignore: got %0d/%h expected 0/ffff", pulse_total - pbase, bus.guess); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_digit(1);
        press_digit(2);
        checks++; if (bus.guess !== 16'h12FF || bus.key_code !== 4'd2) begin failures++; $display("FAIL mid_pre: got %h/%h expected 12ff/2", bus.guess, bus.key_code); end
        key[9] = 1'b1;
        tick(4);
        rst = 1'b0;
        #2;
        checks++; if (bus.guess !== 16'hFFFF || bus.guess_valid !== 1'b0 || bus.key_code !== 4'd0) begin
            failures++; $display("FAIL mid_reset_data: got %h/%b/%h expected ffff/0/0", bus.guess, bus.guess_valid, bus.key_code); end
        checks++; if (bus.key_pulse !== 1'b0 || bus.dup_err !== 1'b0 || bus.tries !== 4'd0 || bus.locked !== 1'b0) begin
            failures++; $display("FAIL mid_reset_status: got %b/%b/%0d/%b expected 0/0/0/0", bus.key_pulse, bus.dup_err, bus.tries, bus.locked); end
        tick(3);
        rst = 1'b1;
        start = cyc;
        pbase = pulse_total;
        tick(6);
        checks++; if (pulse_total - pbase !== 0) begin failures++; $display("FAIL mid_early: got %0d expected 0", pulse_total - pbase); end
        tick(2);
        checks++; if (pulse_total - pbase !== 1 || last_pulse_cyc - start !== 7) begin failures++; $display("FAIL mid_latency: got %0d/%0d expected 1/7", pulse_total - pbase, last_pulse_cyc - start); end
        checks++; if (bus.guess !== 16'h9FFF || codes[codes.size()-1] !== 4'd9) begin failures++; $display("FAIL mid_event: got %h/%h expected 9fff/9", bus.guess, codes[codes.size()-1]); end
        key = '0;
        tick(10);
    endtask

    initial begin
        bus.guess_ack = 1'b0;
        test_reset();
        test_entry();
        test_dup_del();
        test_bounce();
        test_ack();
        test_lockout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
- Upstream stage of the Bulls-and-Cows checker. It takes the ten raw keypad digit lines plus a backspace key, synchronizes and debounces them, and assembles a 4-digit guess with no repeated digits.
- It presents the guess with a valid/ack handshake and counts attempts, locking out entry after the last allowed try.
- It replaces the loose key-to-binary, trigger and shift-in chain in front of the game logic.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz).
- MAX_TRIES, 10: number of acknowledged guesses before lockout (1..15).
- EMPTY_NIBBLE, 4'hF: code placed in unfilled digit positions.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- key  input  10  raw digit keys, bit i = digit i, active-high
- del  input  1  raw backspace key, active-high
- guess_ack  input  1  checker has consumed guess; single-cycle pulse
- guess  output  16  digits, first entered in [15:12], fourth in [3:0]; EMPTY_NIBBLE when unfilled
- guess_valid  output  1  four distinct digits held and not yet acknowledged
- key_code  output  4  binary value of the last accepted digit
- key_pulse  output  1  one-cycle strobe per accepted digit (drives piezo and LCD echo)
- dup_err  output  1  one-cycle strobe when an accepted digit is already in the buffer
- tries  output  4  number of acknowledged guesses
- locked  output  1  high once tries == MAX_TRIES

Behaviour:
- Reset (async, rst=0), all outputs registered:
  - guess=16'hFFFF, count=0, guess_valid=0, key_code=0, key_pulse=0, dup_err=0, tries=0, locked=0.
  - Debounce FSM returns to IDLE and its counter clears.
  - Reset asserted mid-debounce or mid-entry discards everything.
- Input synchronization: key and del each pass through a 2-flop synchronizer. "Sampled" below means the synchronized value.
- Debounce FSM, shared by the 11 lines treated as one vector {del,key}:
  - IDLE: a sampled vector with exactly one bit set moves to PRESS, latches that vector and clears the counter. Zero bits or two or more bits set: stay in IDLE.
  - PRESS: if the sampled vector equals the latched vector, increment the counter; any difference returns to IDLE. When the counter reaches DEBOUNCE_CYCLES-1, go to HELD and emit one accept event (digit or del).
  - HELD: wait for an all-zero vector, then go to RELEASE with the counter cleared.
  - RELEASE: stay while all-zero, counting. Any nonzero sample restarts the count. Reaching DEBOUNCE_CYCLES-1 returns to IDLE.
  - A held key produces exactly one event. No auto-repeat.
- Latency: a one-hot vector stable at the raw input from cycle t produces its event effect on the clock edge ending cycle t+2+DEBOUNCE_CYCLES.
- Entry datapath, on an accept event, evaluated in this priority order:
  1. locked=1: ignore all events.
  2. guess_ack=1 in the same cycle: perform the ack; discard the event.
  3. del event: if count>0, set guess nibble[count-1]=EMPTY_NIBBLE and count-=1. This works at count=4 and drops guess_valid. If count=0, no effect.
  4. Digit d, count<4, d not in buffer: store d at nibble[count], count+=1. Set key_code=d and key_pulse=1 for one cycle.
  5. Digit d already in buffer: dup_err=1 for one cycle. Buffer unchanged. key_pulse still fires and key_code=d.
  6. Digit with count=4: ignored, no strobes.
- guess_valid is registered as (count==4) and rises on the same edge that writes the 4th digit.
- guess_ack is honoured only when guess_valid=1; an ack with guess_valid=0 is ignored. When honoured:
  - guess=16'hFFFF, count=0 and guess_valid=0 on the next edge.
  - tries+=1, saturating at MAX_TRIES.
  - locked=1 on the edge where tries becomes MAX_TRIES.
- guess is stable while guess_valid=1 unless del is accepted.

Test Plan:
- Use DEBOUNCE_CYCLES=4 for all scenarios.
- Press 1,2,3,4 (each held 10 cycles, then released 10 cycles) -> four key_pulse strobes with key_code 1,2,3,4; guess=16'h1234, guess_valid=1 on the 4th strobe edge.
- Buffer 1,2; press 2 -> dup_err one cycle, key_code=2, guess=16'h12FF; then del -> 16'h1FFF; then 5 -> 16'h15FF.
- Raw key[7] toggling every 2 cycles for 20 cycles, then held 10 -> exactly one key_pulse with key_code=7. key[3]|key[5] held together -> no event.
- guess_valid with guess=16'h5678, pulse guess_ack -> next edge guess=16'hFFFF, guess_valid=0, tries=1. An ack when guess_valid=0 -> tries unchanged.
- Ten full guess/ack rounds with MAX_TRIES=10 -> tries=10, locked=1; further digit presses give no key_pulse and guess stays 16'hFFFF.
- Assert rst with guess=16'h12FF while the key[9] press is in PRESS -> all outputs return to reset values; releasing rst with key[9] still held needs a full DEBOUNCE_CYCLES stable period before the event fires.
